id_pipe: RTL and testbench

Registered, parametrised instruction-decode stage with clocked A/B accumulators, writeback forwarding and load/ALU hazard interlock. It sits between instruction fetch and EX. It decodes the 16-bit instruction word (opcode macros from `instrDefine.v`) and presents muxed operands, control and branch target through an ID/EX pipeline register. It replaces the combinational decoder/accumulator pair.

---
 rtl/id_pipe.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_id_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe.sv
// id_pipe: registered instruction-decode stage.
// Decodes a 16-bit instruction, muxes accumulator/constant operands with
// writeback forwarding, interlocks on outstanding accumulator writes and
// presents everything to EX through a single ID/EX register.
module id_pipe #(
  parameter int DATA_W = 8,   // accumulator width, 8 or more
  parameter int PC_W   = 10   // program-counter width, 10 or more
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [PC_W-1:0]   new_pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic              wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [5:0]        out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_dest,
  output logic              out_wr,
  output logic [9:0]        out_addr,
  output logic [PC_W-1:0]   out_target,
  output logic              out_branch,
  output logic              out_jump,
  output logic              illegal,
  output logic [DATA_W-1:0] acc_a,
  output logic [DATA_W-1:0] acc_b
);

  // Opcode map (instruction bits [15:10]); every other code is undefined.
  localparam logic [5:0] OP_LDA   = 6'h01;
  localparam logic [5:0] OP_LDB   = 6'h02;
  localparam logic [5:0] OP_STA   = 6'h03;
  localparam logic [5:0] OP_STB   = 6'h04;
  localparam logic [5:0] OP_LDCA  = 6'h05;
  localparam logic [5:0] OP_LDCB  = 6'h06;
  localparam logic [5:0] OP_ADDA  = 6'h08;
  localparam logic [5:0] OP_ADDB  = 6'h09;
  localparam logic [5:0] OP_SUBA  = 6'h0A;
  localparam logic [5:0] OP_SUBB  = 6'h0B;
  localparam logic [5:0] OP_ANDA  = 6'h0C;
  localparam logic [5:0] OP_ANDB  = 6'h0D;
  localparam logic [5:0] OP_ORA   = 6'h0E;
  localparam logic [5:0] OP_ORB   = 6'h0F;
  localparam logic [5:0] OP_ADDCA = 6'h10;
  localparam logic [5:0] OP_ADDCB = 6'h11;
  localparam logic [5:0] OP_SUBCA = 6'h12;
  localparam logic [5:0] OP_SUBCB = 6'h13;
  localparam logic [5:0] OP_ANDCA = 6'h14;
  localparam logic [5:0] OP_ANDCB = 6'h15;
  localparam logic [5:0] OP_ORCA  = 6'h16;
  localparam logic [5:0] OP_ORCB  = 6'h17;
  localparam logic [5:0] OP_ASLA  = 6'h18;
  localparam logic [5:0] OP_ASRA  = 6'h19;
  localparam logic [5:0] OP_BAEQ  = 6'h20;
  localparam logic [5:0] OP_BANE  = 6'h21;
  localparam logic [5:0] OP_BBEQ  = 6'h22;
  localparam logic [5:0] OP_BBNE  = 6'h23;
  localparam logic [5:0] OP_JMP   = 6'h28;

  // Operand-source selects.
  localparam logic [1:0] SA_ZERO  = 2'd0;
  localparam logic [1:0] SA_ACCA  = 2'd1;
  localparam logic [1:0] SA_ACCB  = 2'd2;
  localparam logic [1:0] SA_CONST = 2'd3;
  localparam logic [1:0] SB_ZERO  = 2'd0;
  localparam logic [1:0] SB_ACCB  = 2'd1;
  localparam logic [1:0] SB_CONST = 2'd2;

  logic [5:0]        op_s;
  logic [9:0]        info_s;
  logic [DATA_W-1:0] const_s;

  logic              legal_s;
  logic              rd_a_s;
  logic              rd_b_s;
  logic              ldc_a_s;
  logic              ldc_b_s;
  logic              wr_s;
  logic              dest_s;
  logic              branch_s;
  logic              jump_s;
  logic [1:0]        sel_a_s;
  logic [1:0]        sel_b_s;

  logic              hit_a_s;
  logic              hit_b_s;
  logic [DATA_W-1:0] fwd_a_s;
  logic [DATA_W-1:0] fwd_b_s;
  logic              hazard_s;
  logic              accept_s;
  logic              issue_s;

  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;
  logic [PC_W-1:0]   br_off_s;
  logic [PC_W-1:0]   target_s;

  logic [1:0]        pending_r;
  logic [1:0]        clear_s;
  logic [1:0]        set_s;

  assign op_s    = instr[15:10];
  assign info_s  = instr[9:0];
  assign const_s = DATA_W'(info_s[7:0]);

  // Decode the opcode into read/write/control flags and operand selects.
  always_comb begin
    legal_s  = 1'b1;
    rd_a_s   = 1'b0;
    rd_b_s   = 1'b0;
    ldc_a_s  = 1'b0;
    ldc_b_s  = 1'b0;
    wr_s     = 1'b0;
    dest_s   = 1'b0;
    branch_s = 1'b0;
    jump_s   = 1'b0;
    sel_a_s  = SA_ZERO;
    sel_b_s  = SB_ZERO;
    case (op_s)
      OP_LDA: begin
        wr_s = 1'b1;
      end
      OP_LDB: begin
        wr_s   = 1'b1;
        dest_s = 1'b1;
      end
      OP_STA: begin
        rd_a_s  = 1'b1;
        sel_a_s = SA_ACCA;
      end
      OP_STB: begin
        rd_b_s  = 1'b1;
        sel_b_s = SB_ACCB;
      end
      OP_LDCA: begin
        ldc_a_s = 1'b1;
      end
      OP_LDCB: begin
        ldc_b_s = 1'b1;
        dest_s  = 1'b1;
      end
      OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA: begin
        rd_a_s  = 1'b1;
        rd_b_s  = 1'b1;
        sel_a_s = SA_ACCA;
        sel_b_s = SB_ACCB;
        wr_s    = 1'b1;
      end
      OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB: begin
        rd_a_s  = 1'b1;
        rd_b_s  = 1'b1;
        sel_a_s = SA_ACCA;
        sel_b_s = SB_ACCB;
        wr_s    = 1'b1;
        dest_s  = 1'b1;
      end
      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA: begin
        rd_a_s  = 1'b1;
        sel_a_s = SA_ACCA;
        sel_b_s = SB_CONST;
        wr_s    = 1'b1;
      end
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: begin
        rd_b_s  = 1'b1;
        sel_a_s = SA_CONST;
        sel_b_s = SB_ACCB;
        wr_s    = 1'b1;
        dest_s  = 1'b1;
      end
      OP_ASLA, OP_ASRA: begin
        rd_a_s  = 1'b1;
        sel_a_s = SA_ACCA;
        wr_s    = 1'b1;
      end
      OP_BAEQ, OP_BANE: begin
        rd_a_s   = 1'b1;
        sel_a_s  = SA_ACCA;
        branch_s = 1'b1;
      end
      OP_BBEQ, OP_BBNE: begin
        rd_b_s   = 1'b1;
        sel_a_s  = SA_ACCB;
        branch_s = 1'b1;
      end
      OP_JMP: begin
        jump_s = 1'b1;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Writeback forwarding and the load/ALU interlock; an LDC into a pending
  // accumulator also blocks so the late writeback cannot overwrite it.
  assign hit_a_s  = wb_en && (wb_sel == 1'b0);
  assign hit_b_s  = wb_en && (wb_sel == 1'b1);
  assign fwd_a_s  = hit_a_s ? wb_data : acc_a;
  assign fwd_b_s  = hit_b_s ? wb_data : acc_b;
  assign hazard_s = in_valid &&
                    (((rd_a_s || ldc_a_s) && pending_r[0] && !hit_a_s) ||
                     ((rd_b_s || ldc_b_s) && pending_r[1] && !hit_b_s));
  assign in_ready = !stall && !hazard_s;
  assign accept_s = in_valid && in_ready && !flush;
  assign issue_s  = accept_s && legal_s;

  // Operand muxes: accumulators (forwarded), the constant, or zero.
  always_comb begin
    opa_s = {DATA_W{1'b0}};
    opb_s = {DATA_W{1'b0}};
    case (sel_a_s)
      SA_ACCA:  opa_s = fwd_a_s;
      SA_ACCB:  opa_s = fwd_b_s;
      SA_CONST: opa_s = const_s;
      default:  opa_s = {DATA_W{1'b0}};
    endcase
    case (sel_b_s)
      SB_ACCB:  opb_s = fwd_b_s;
      SB_CONST: opb_s = const_s;
      default:  opb_s = {DATA_W{1'b0}};
    endcase
  end

  // Branch target wraps modulo 2^PC_W; jump target is the raw info field.
  always_comb begin
    br_off_s = {{(PC_W-6){info_s[5]}}, info_s[5:0]};
    target_s = branch_s ? (new_pc + br_off_s)
             : (jump_s ? PC_W'(info_s) : {PC_W{1'b0}});
  end

  // Pending-write bookkeeping: set on issue wins over a same-cycle clear.
  assign clear_s = {hit_b_s, hit_a_s};
  assign set_s   = (issue_s && wr_s) ? (dest_s ? 2'b10 : 2'b01) : 2'b00;

  // Pending-write bits; flush forgets every outstanding write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= 2'b00;
    end else if (flush) begin
      pending_r <= 2'b00;
    end else begin
      pending_r <= (pending_r & ~clear_s) | set_s;
    end
  end

  // Accumulators: writeback every cycle, an issued LDC overrides it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_a <= {DATA_W{1'b0}};
      acc_b <= {DATA_W{1'b0}};
    end else begin
      acc_a <= (issue_s && ldc_a_s) ? const_s : (hit_a_s ? wb_data : acc_a);
      acc_b <= (issue_s && ldc_b_s) ? const_s : (hit_b_s ? wb_data : acc_b);
    end
  end

  // ID/EX register: flush kills, stall holds, issue loads, otherwise bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_op     <= 6'h00;
      out_a      <= {DATA_W{1'b0}};
      out_b      <= {DATA_W{1'b0}};
      out_dest   <= 1'b0;
      out_wr     <= 1'b0;
      out_addr   <= 10'h000;
      out_target <= {PC_W{1'b0}};
      out_branch <= 1'b0;
      out_jump   <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (stall) begin
      illegal <= 1'b0;
    end else if (issue_s) begin
      out_valid  <= 1'b1;
      out_op     <= op_s;
      out_a      <= opa_s;
      out_b      <= opb_s;
      out_dest   <= dest_s;
      out_wr     <= wr_s;
      out_addr   <= info_s;
      out_target <= target_s;
      out_branch <= branch_s;
      out_jump   <= jump_s;
      illegal    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= accept_s && !legal_s;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: table-driven directed bench for id_pipe plus hand-written
// sequences for interlock, stall, flush and asynchronous reset.
module tb_id_pipe;

  localparam logic [5:0] OP_LDA   = 6'h01;
  localparam logic [5:0] OP_LDB   = 6'h02;
  localparam logic [5:0] OP_STA   = 6'h03;
  localparam logic [5:0] OP_STB   = 6'h04;
  localparam logic [5:0] OP_LDCA  = 6'h05;
  localparam logic [5:0] OP_LDCB  = 6'h06;
  localparam logic [5:0] OP_ADDA  = 6'h08;
  localparam logic [5:0] OP_SUBA  = 6'h0A;
  localparam logic [5:0] OP_ADDCA = 6'h10;
  localparam logic [5:0] OP_ORCB  = 6'h17;
  localparam logic [5:0] OP_ASLA  = 6'h18;
  localparam logic [5:0] OP_BANE  = 6'h21;
  localparam logic [5:0] OP_BBEQ  = 6'h22;
  localparam logic [5:0] OP_JMP   = 6'h28;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [9:0]  new_pc;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic        wb_sel;
  logic [7:0]  wb_data;
  logic        out_valid;
  logic [5:0]  out_op;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic        out_dest;
  logic        out_wr;
  logic [9:0]  out_addr;
  logic [9:0]  out_target;
  logic        out_branch;
  logic        out_jump;
  logic        illegal;
  logic [7:0]  acc_a;
  logic [7:0]  acc_b;

  int passed = 0;
  int total  = 0;

  id_pipe #(.DATA_W(8), .PC_W(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .new_pc(new_pc), .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .out_dest(out_dest), .out_wr(out_wr), .out_addr(out_addr),
    .out_target(out_target), .out_branch(out_branch), .out_jump(out_jump),
    .illegal(illegal), .acc_a(acc_a), .acc_b(acc_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [15:0] ins;
    logic [9:0]  pc;
    logic        wbe;
    logic        wbs;
    logic [7:0]  wbd;
    logic        e_rdy;
    logic        e_vld;
    logic [5:0]  e_op;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
    logic        e_dest;
    logic        e_wr;
    logic        e_br;
    logic        e_jmp;
    logic [9:0]  e_tgt;
    logic        e_ill;
    logic [7:0]  e_acca;
    logic [7:0]  e_accb;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [9:0] pc,
                       input logic we, input logic ws, input logic [7:0] wd,
                       input logic st, input logic fl);
    in_valid = v; instr = ins; new_pc = pc;
    wb_en = we; wb_sel = ws; wb_data = wd; stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        vld  instr                   pc       wbe   wbs   wbd    rdy   vld   op        a      b      dest  wr    br    jmp   tgt      ill   acca   accb
    tbl[0]  = '{1'b1, {OP_LDCA, 10'h025}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_LDCA,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h25, 8'h00};
    tbl[1]  = '{1'b1, {OP_LDCB, 10'h010}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_LDCB,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h25, 8'h10};
    tbl[2]  = '{1'b1, {OP_ADDCA,10'h003}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_ADDCA, 8'h25, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 8'h25, 8'h10};
    tbl[3]  = '{1'b1, {OP_ORCB, 10'h040}, 10'h000, 1'b1, 1'b0, 8'h28, 1'b1, 1'b1, OP_ORCB,  8'h40, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 8'h28, 8'h10};
    tbl[4]  = '{1'b1, {OP_BANE, 10'h03E}, 10'h003, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_BANE,  8'h28, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h001, 1'b0, 8'h28, 8'h10};
    tbl[5]  = '{1'b1, {OP_BANE, 10'h001}, 10'h3FF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_BANE,  8'h28, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 8'h28, 8'h10};
    tbl[6]  = '{1'b1, {OP_JMP,  10'h2A5}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_JMP,   8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2A5, 1'b0, 8'h28, 8'h10};
    tbl[7]  = '{1'b1, {OP_BBEQ, 10'h005}, 10'h010, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, OP_BBEQ,  8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h015, 1'b0, 8'h28, 8'h0F};
    tbl[8]  = '{1'b1, {OP_STB,  10'h033}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_STB,   8'h00, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h28, 8'h0F};
    tbl[9]  = '{1'b1, {OP_STA,  10'h012}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_STA,   8'h28, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h28, 8'h0F};
    tbl[10] = '{1'b1, {6'h3F,   10'h000}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'h00,    8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 8'h28, 8'h0F};
    tbl[11] = '{1'b0, {6'h00,   10'h000}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'h00,    8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h28, 8'h0F};
    tbl[12] = '{1'b1, {OP_ADDA, 10'h000}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_ADDA,  8'h28, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 8'h28, 8'h0F};
    tbl[13] = '{1'b1, {OP_LDCA, 10'h077}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00,    8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h28, 8'h0F};
    tbl[14] = '{1'b1, {OP_LDCA, 10'h077}, 10'h000, 1'b1, 1'b0, 8'h99, 1'b1, 1'b1, OP_LDCA,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 8'h77, 8'h0F};
    tbl[15] = '{1'b1, {OP_ASLA, 10'h000}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_ASLA,  8'h77, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 8'h77, 8'h0F};
    tbl[16] = '{1'b1, {OP_LDB,  10'h1C4}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, OP_LDB,   8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 8'h77, 8'h0F};

    // Reset state.
    reset = 1'b1;
    drive(1'b0, 16'h0000, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_acc_a", acc_a, 8'h00);
    chk("rst_acc_b", acc_b, 8'h00);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();
    reset = 1'b0;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].vld, tbl[i].ins, tbl[i].pc, tbl[i].wbe, tbl[i].wbs, tbl[i].wbd, 1'b0, 1'b0);
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      tick();
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_vld);
      chk($sformatf("v%0d_illegal", i), illegal, tbl[i].e_ill);
      chk($sformatf("v%0d_acc_a", i), acc_a, tbl[i].e_acca);
      chk($sformatf("v%0d_acc_b", i), acc_b, tbl[i].e_accb);
      if (tbl[i].e_vld) begin
        chk($sformatf("v%0d_out_op", i), out_op, tbl[i].e_op);
        chk($sformatf("v%0d_out_a", i), out_a, tbl[i].e_a);
        chk($sformatf("v%0d_out_b", i), out_b, tbl[i].e_b);
        chk($sformatf("v%0d_out_addr", i), out_addr, tbl[i].ins[9:0]);
        chk($sformatf("v%0d_out_wr", i), out_wr, tbl[i].e_wr);
        chk($sformatf("v%0d_out_branch", i), out_branch, tbl[i].e_br);
        chk($sformatf("v%0d_out_jump", i), out_jump, tbl[i].e_jmp);
        if (tbl[i].e_wr) chk($sformatf("v%0d_out_dest", i), out_dest, tbl[i].e_dest);
        if (tbl[i].e_br || tbl[i].e_jmp) chk($sformatf("v%0d_out_target", i), out_target, tbl[i].e_tgt);
      end
    end

    // Clean restart for the multi-cycle sequences.
    drive(1'b0, 16'h0000, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();

    // ADDA then SUBA: SUBA interlocked until writeback of A, then forwarded.
    drive(1'b1, {OP_LDCA, 10'h025}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, {OP_LDCB, 10'h010}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("seq_ldc_acc_a", acc_a, 8'h25);
    chk("seq_ldc_acc_b", acc_b, 8'h10);
    chk("seq_ldc_out_wr", out_wr, 1'b0);
    drive(1'b1, {OP_ADDA, 10'h000}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("seq_adda_out_a", out_a, 8'h25);
    chk("seq_adda_out_b", out_b, 8'h10);
    drive(1'b1, {OP_SUBA, 10'h000}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("haz%0d_in_ready", c), in_ready, 1'b0);
      tick();
      chk($sformatf("haz%0d_bubble", c), out_valid, 1'b0);
    end
    drive(1'b1, {OP_SUBA, 10'h000}, 10'h000, 1'b1, 1'b0, 8'h35, 1'b0, 1'b0);
    #1;
    chk("haz_wb_in_ready", in_ready, 1'b1);
    tick();
    chk("suba_out_valid", out_valid, 1'b1);
    chk("suba_out_op", out_op, OP_SUBA);
    chk("suba_out_a", out_a, 8'h35);
    chk("suba_out_b", out_b, 8'h10);
    chk("suba_acc_a", acc_a, 8'h35);

    // ORCB in the register, then 3 stall cycles with a B writeback.
    drive(1'b1, {OP_ORCB, 10'h040}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("orcb_out_a", out_a, 8'h40);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, {OP_JMP, 10'h111}, 10'h000, (c == 1), 1'b1, 8'h0F, 1'b1, 1'b0);
      #1;
      chk($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
      tick();
      chk($sformatf("stall%0d_out_valid", c), out_valid, 1'b1);
      chk($sformatf("stall%0d_out_op", c), out_op, OP_ORCB);
      chk($sformatf("stall%0d_out_a", c), out_a, 8'h40);
      chk($sformatf("stall%0d_out_b", c), out_b, 8'h10);
      chk($sformatf("stall%0d_out_jump", c), out_jump, 1'b0);
    end
    chk("stall_acc_b", acc_b, 8'h0F);
    chk("stall_acc_a", acc_a, 8'h35);

    // Flush on an accepted ADDCA, and on an LDCB.
    drive(1'b1, {OP_ADDCA, 10'h001}, 10'h000, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1);
    #1;
    chk("flush_in_ready", in_ready, 1'b1);
    tick();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_acc_a", acc_a, 8'h44);
    drive(1'b1, {OP_LDCB, 10'h055}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("flush_ldcb_acc_b", acc_b, 8'h0F);
    chk("flush_ldcb_out_valid", out_valid, 1'b0);
    drive(1'b1, {OP_ADDA, 10'h000}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("postflush_in_ready", in_ready, 1'b1);
    tick();
    chk("postflush_out_valid", out_valid, 1'b1);
    chk("postflush_out_a", out_a, 8'h44);
    chk("postflush_out_b", out_b, 8'h0F);

    // Reset in the middle of a hazard.
    drive(1'b1, {OP_SUBA, 10'h000}, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("rhaz_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_op", out_op, 6'h00);
    chk("arst_out_a", out_a, 8'h00);
    chk("arst_out_wr", out_wr, 1'b0);
    chk("arst_acc_a", acc_a, 8'h00);
    chk("arst_acc_b", acc_b, 8'h00);
    chk("arst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    tick();
    chk("after_rst_out_valid", out_valid, 1'b1);
    chk("after_rst_out_op", out_op, OP_SUBA);
    chk("after_rst_out_a", out_a, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
